// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : Registered integer ALU for the execute stage. Computes one op per
//            cycle and captures result plus overflow/zero flags on posedge.
// Revision : 1.0  initial release
// ============================================================================
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       alufn,
    output logic [WIDTH-1:0] otp,
    output logic             overflow,
    output logic             zero
);

    localparam int          c_shw   = $clog2(WIDTH);
    localparam logic [5:0]  c_add   = 6'b000000;
    localparam logic [5:0]  c_sub   = 6'b000001;
    localparam logic [5:0]  c_mul   = 6'b000010;
    localparam logic [5:0]  c_mulhu = 6'b000011;
    localparam logic [5:0]  c_and   = 6'b000100;
    localparam logic [5:0]  c_or    = 6'b000101;
    localparam logic [5:0]  c_xor   = 6'b000110;
    localparam logic [5:0]  c_nor   = 6'b000111;
    localparam logic [5:0]  c_sll   = 6'b001000;
    localparam logic [5:0]  c_srl   = 6'b001001;
    localparam logic [5:0]  c_sra   = 6'b001010;
    localparam logic [5:0]  c_slt   = 6'b001100;
    localparam logic [5:0]  c_sltu  = 6'b001101;
    localparam logic [5:0]  c_passb = 6'b001110;

    logic [WIDTH-1:0]          w_sum;
    logic [WIDTH-1:0]          w_diff;
    logic signed [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]          w_mulhu;
    logic [c_shw-1:0]          w_shamt;
    logic [WIDTH-1:0]          w_res;
    logic                      w_ovf;

    assign w_sum    = a + b;
    assign w_diff   = a - b;
    assign w_prod_s = $signed(a) * $signed(b);
    // Only the upper half of the unsigned product is ever needed.
    assign w_mulhu  = WIDTH'(({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b}) >> WIDTH);
    assign w_shamt  = b[c_shw-1:0];

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (alufn)
            c_add: begin
                w_res = w_sum;
                w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            c_sub: begin
                w_res = w_diff;
                w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            c_mul: begin
                w_res = w_prod_s[WIDTH-1:0];
                // Product fits only if the high half is a pure sign extension.
                w_ovf = w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}};
            end
            c_mulhu: w_res = w_mulhu;
            c_and:   w_res = a & b;
            c_or:    w_res = a | b;
            c_xor:   w_res = a ^ b;
            c_nor:   w_res = ~(a | b);
            c_sll:   w_res = a << w_shamt;
            c_srl:   w_res = a >> w_shamt;
            c_sra:   w_res = $signed(a) >>> w_shamt;
            c_slt:   w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            c_sltu:  w_res = {{(WIDTH-1){1'b0}}, a < b};
            c_passb: w_res = b;
            default: begin
                w_res = '0;
                w_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            otp      <= '0;
            overflow <= 1'b0;
            zero     <= 1'b1;
        end else begin
            otp      <= w_res;
            overflow <= w_ovf;
            zero     <= (w_res == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Brief    : Directed self-checking bench for alu with hand-computed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  alufn;
    logic [31:0] otp;
    logic        overflow;
    logic        zero;

    int n_cmp = 0;
    int n_err = 0;

    alu #(.WIDTH(32)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .alufn    (alufn),
        .otp      (otp),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] e_otp,
                          input logic e_ov, input logic e_z);
        @(negedge clk);
        alufn = op;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        check({tag, ".otp"}, otp, e_otp);
        check({tag, ".ov"},  {31'b0, overflow}, {31'b0, e_ov});
        check({tag, ".z"},   {31'b0, zero},     {31'b0, e_z});
    endtask

    initial begin
        rst   = 1'b1;
        a     = '0;
        b     = '0;
        alufn = 6'b000000;
        #2;
        check("rst.otp", otp, 32'h0);
        check("rst.ov",  {31'b0, overflow}, 32'h0);
        check("rst.z",   {31'b0, zero},     32'h1);

        @(negedge clk);
        rst = 1'b0;

        run_op("add",      6'b000000, 32'h1,        32'h1,        32'h2,        1'b0, 1'b0);
        run_op("sub",      6'b000001, 32'h13,       32'h2,        32'h11,       1'b0, 1'b0);
        run_op("mul",      6'b000010, 32'h13,       32'h2,        32'h26,       1'b0, 1'b0);
        run_op("mul_neg",  6'b000010, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFA, 1'b0, 1'b0);
        run_op("mulhu",    6'b000011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("and",      6'b000100, 32'h1,        32'h0,        32'h0,        1'b0, 1'b1);
        run_op("or",       6'b000101, 32'h1,        32'h0,        32'h1,        1'b0, 1'b0);
        run_op("xor",      6'b000110, 32'h1,        32'h0,        32'h1,        1'b0, 1'b0);
        run_op("nor",      6'b000111, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("sll",      6'b001000, 32'h1,        32'h3,        32'h8,        1'b0, 1'b0);
        run_op("srl",      6'b001001, 32'h10,       32'h3,        32'h2,        1'b0, 1'b0);
        run_op("sra",      6'b001010, 32'h80000000, 32'h4,        32'hF8000000, 1'b0, 1'b0);
        run_op("sll_b23",  6'b001000, 32'h1,        32'h23,       32'h8,        1'b0, 1'b0);
        run_op("sra_b20",  6'b001010, 32'h80000000, 32'h20,       32'h80000000, 1'b0, 1'b0);
        run_op("add_ovf",  6'b000000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 1'b0);
        run_op("sub_ovf",  6'b000001, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 1'b0);
        run_op("mul_ovf",  6'b000010, 32'h10000,    32'h10000,    32'h0,        1'b1, 1'b1);
        run_op("slt",      6'b001100, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0);
        run_op("sltu",     6'b001101, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b1);
        run_op("passb",    6'b001110, 32'hDEADBEEF, 32'h12345000, 32'h12345000, 1'b0, 1'b0);
        run_op("undef3f",  6'b111111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b1);
        run_op("undef0b",  6'b001011, 32'h7FFFFFFF, 32'h1,        32'h0,        1'b0, 1'b1);

        // Leave a nonzero, overflowing result in the register, then reset between edges.
        run_op("pre_rst",  6'b000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst.otp", otp, 32'h0);
        check("arst.ov",  {31'b0, overflow}, 32'h0);
        check("arst.z",   {31'b0, zero},     32'h1);
        @(posedge clk);
        #1;
        check("hold.otp", otp, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op("post_rst", 6'b000101, 32'hA0,       32'h05,       32'hA5,       1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
